// File: rtl/vector_write_back_buffer.sv
// Vector write-back buffer: queues execute/LSU results and replays them
// to the vector register file one write at a time, with a pending-rd scoreboard.
module vector_write_back_buffer #(
    parameter int LEN         = 32,
    parameter int VECTOR_SIZE = 8,
    parameter int DEPTH       = 2,
    localparam int VLEN       = VECTOR_SIZE * LEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_vm,
    input  logic [VLEN-1:0] in_mask,
    input  logic [VLEN-1:0] in_data,
    input  logic [LEN-1:0]  in_length,
    input  logic [2:0]      in_data_type,
    input  logic [1:0]      rf_status,
    output logic [1:0]      rf_signal,
    output logic [4:0]      rf_rd,
    output logic            rf_vm,
    output logic [VLEN-1:0] rf_mask,
    output logic [VLEN-1:0] rf_data,
    output logic [LEN-1:0]  rf_length,
    output logic [2:0]      rf_data_type,
    output logic            write_back_enabled,
    output logic [31:0]     pending_rd,
    output logic            wb_done,
    output logic            wb_error,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] RF_NOP          = 2'b00;
    localparam logic [1:0] RF_FINISHED     = 2'b01;
    localparam logic [1:0] VECTOR_RF_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [4:0]      rd_q   [DEPTH];
    logic            vm_q   [DEPTH];
    logic [VLEN-1:0] mask_q [DEPTH];
    logic [VLEN-1:0] data_q [DEPTH];
    logic [LEN-1:0]  len_q  [DEPTH];
    logic [2:0]      type_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [AW:0]   count_q;

    logic push, pop, head_vld;

    // Types 0..3 are byte/half/word/double; anything with bit 2 set is illegal.
    function automatic logic legal(input logic [2:0] t);
        legal = (t[2] == 1'b0);
    endfunction

    // Element count limited to what fits in one VLEN-bit register.
    function automatic logic [LEN-1:0] clamp(input logic [LEN-1:0] len,
                                             input logic [2:0]     t);
        logic [LEN-1:0] maxe;
        maxe  = LEN'(VLEN / 8) >> t[1:0];
        clamp = (legal(t) && len > maxe) ? maxe : len;
    endfunction

    assign in_ready = (count_q != (AW+1)'(DEPTH));
    assign push     = rdy_in & in_valid & in_ready;
    assign rd_nxt   = rd_ptr_q + AW'(1);
    assign head_vld = vld_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        wb_done  = 1'b0;
        wb_error = 1'b0;
        if (rdy_in) begin
            unique case (state_q)
                IDLE: begin
                    if (head_vld) begin
                        if (legal(type_q[rd_ptr_q])) begin
                            state_d = WRITE;
                        end else begin
                            pop      = 1'b1;
                            wb_error = 1'b1;
                        end
                    end else if (push && legal(in_data_type)) begin
                        state_d = WRITE;
                    end
                end
                WRITE: state_d = WAIT;
                WAIT: begin
                    if (rf_status == RF_FINISHED) begin
                        pop     = 1'b1;
                        wb_done = 1'b1;
                        if (count_q > (AW+1)'(1)) begin
                            state_d = legal(type_q[rd_nxt]) ? WRITE : IDLE;
                        end else begin
                            state_d = (push && legal(in_data_type)) ? WRITE : IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_nxt;
            end
            if (push) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; it is qualified by vld_q everywhere.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= in_rd;
            vm_q[wr_ptr_q]   <= in_vm;
            mask_q[wr_ptr_q] <= in_mask;
            data_q[wr_ptr_q] <= in_data;
            len_q[wr_ptr_q]  <= clamp(in_length, in_data_type);
            type_q[wr_ptr_q] <= in_data_type;
        end
    end

    always_comb begin
        pending_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pending_rd[rd_q[i]] = 1'b1;
        end
    end

    assign write_back_enabled = (state_q == WRITE);
    assign rf_signal    = (state_q == WRITE) ? VECTOR_RF_WRITE : RF_NOP;
    assign rf_rd        = head_vld ? rd_q[rd_ptr_q]   : '0;
    assign rf_vm        = head_vld ? vm_q[rd_ptr_q]   : 1'b0;
    assign rf_mask      = head_vld ? mask_q[rd_ptr_q] : '0;
    assign rf_data      = head_vld ? data_q[rd_ptr_q] : '0;
    assign rf_length    = head_vld ? len_q[rd_ptr_q]  : '0;
    assign rf_data_type = head_vld ? type_q[rd_ptr_q] : '0;
    assign busy         = (count_q != '0) || (state_q != IDLE);

endmodule
